apx_add_pipe: RTL and testbench

Pipelined, run-time configurable approximate adder with a valid/ready stream interface and a built-in error monitor. Successor to the fixed truncated/lower-OR adders in the integer approximate-operator library. Adds per-transaction selection of approximation mode and approximate-bit count, a carry-out bit, back-pressure, and on-line accumulation of absolute error against the exact sum. Intended for precision/energy sweep experiments, where one instance replaces a family of fixed-configuration adders.

---
 rtl/apx_add_pipe_if.sv | 37 +++
 rtl/apx_add_pipe.sv | 166 ++++++++++++++++
 tb/tb_apx_add_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apx_add_pipe_if.sv
// apx_add_pipe_if
//   Operand/result stream bundle for the approximate adder pipeline.
//   Ports (slave = adder side):
//     in_valid/in_ready  operand beat handshake
//     a, b               unsigned operands (DWA / DWB bits)
//     mode               0 exact, 1 truncate, 2 lower-OR, 3 truncate+compensate
//     k                  approximate low-bit count (clamped inside the adder)
//     out_valid/out_ready result handshake
//     c                  approximate sum including carry-out (DWO+1 bits)
interface apx_add_pipe_if #(
  parameter int DWA       = 16,
  parameter int DWB       = 16,
  parameter int DW_AC_MAX = 8
);
  localparam int DWO = (DWA > DWB) ? DWA : DWB;
  localparam int KW  = $clog2(DW_AC_MAX + 1);

  logic           in_valid;
  logic           in_ready;
  logic [DWA-1:0] a;
  logic [DWB-1:0] b;
  logic [1:0]     mode;
  logic [KW-1:0]  k;
  logic           out_valid;
  logic           out_ready;
  logic [DWO:0]   c;

  modport master (
    output in_valid, a, b, mode, k, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, mode, k, out_ready,
    output in_ready, out_valid, c
  );
endinterface

// File: rtl/apx_add_pipe.sv
// apx_add_pipe
//   Two-stage pipelined approximate adder with per-beat mode/k selection,
//   valid/ready back-pressure and an absolute-error monitor.
//   Ports:
//     clk         clock, all state on rising edge
//     rst_n       asynchronous active-low reset
//     io          operand/result stream (apx_add_pipe_if.slave)
//     clr_stats   synchronous clear of the monitor registers
//     err_acc     saturating sum of |exact - c|
//     err_max     largest |exact - c| seen
//     sample_cnt  saturating count of monitored results
module apx_add_pipe #(
  parameter int DWA       = 16,
  parameter int DWB       = 16,
  parameter int DW_AC_MAX = 8,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 16,
  localparam int DWO      = (DWA > DWB) ? DWA : DWB
) (
  input  logic               clk,
  input  logic               rst_n,
  apx_add_pipe_if.slave      io,
  input  logic               clr_stats,
  output logic [ACC_W-1:0]   err_acc,
  output logic [DWO:0]       err_max,
  output logic [CNT_W-1:0]   sample_cnt
);

  localparam int KW = $clog2(DW_AC_MAX + 1);
  localparam int SW = ((ACC_W > DWO + 1) ? ACC_W : DWO + 1) + 1;

  logic [DWO-1:0] a_ext;
  logic [DWO-1:0] b_ext;
  logic [KW-1:0]  k_eff;
  logic [DWO-1:0] lo_mask;
  logic [DWO-1:0] lo_res;

  logic           s1_valid;
  logic [DWO-1:0] s1_lo;
  logic [DWO-1:0] s1_ua;
  logic [DWO-1:0] s1_ub;
  logic [DWO:0]   s1_exact;

  logic           s2_valid;
  logic [DWO:0]   s2_c;
  logic [DWO:0]   s2_exact;

  logic           s1_load;
  logic           s2_load;
  logic           out_hs;
  logic [DWO:0]   err;
  logic [SW-1:0]  acc_sum;
  logic [ACC_W-1:0] acc_next;

  assign a_ext = DWO'(io.a);
  assign b_ext = DWO'(io.b);

  // Exact mode is folded into the approximate path by forcing k to zero,
  // which makes the low part empty and the upper add cover every bit.
  always_comb begin
    k_eff = io.k;
    if (io.k > KW'(DW_AC_MAX)) begin
      k_eff = KW'(DW_AC_MAX);
    end
    if (io.mode == 2'd0) begin
      k_eff = '0;
    end
  end

  assign lo_mask = (DWO'(1) << k_eff) - DWO'(1);

  // Low-part result; the upper sum always has zeros below bit k, so this is
  // simply OR-ed into it in the second stage.
  always_comb begin
    lo_res = '0;
    case (io.mode)
      2'd2: lo_res = (a_ext | b_ext) & lo_mask;
      2'd3: begin
        if (k_eff != '0) begin
          lo_res = DWO'(1) << (k_eff - KW'(1));
        end
      end
      default: lo_res = '0;
    endcase
  end

  // A stage loads when it is empty or its successor is draining it.
  assign s2_load     = !s2_valid || io.out_ready;
  assign s1_load     = !s1_valid || s2_load;
  assign io.in_ready = s1_load;
  assign io.out_valid = s2_valid;
  assign io.c         = s2_c;
  assign out_hs       = s2_valid && io.out_ready;

  // Two-stage data path: S1 splits the operands, S2 does the carry-isolated
  // upper add. The exact sum rides along for the error monitor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_ua    <= '0;
      s1_ub    <= '0;
      s1_exact <= '0;
      s2_valid <= 1'b0;
      s2_c     <= '0;
      s2_exact <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= io.in_valid;
        if (io.in_valid) begin
          s1_lo    <= lo_res;
          s1_ua    <= a_ext & ~lo_mask;
          s1_ub    <= b_ext & ~lo_mask;
          s1_exact <= {1'b0, a_ext} + {1'b0, b_ext};
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_c     <= ({1'b0, s1_ua} + {1'b0, s1_ub}) | {1'b0, s1_lo};
          s2_exact <= s1_exact;
        end
      end
    end
  end

  // Truncate+compensate can overshoot the exact sum, so the magnitude is
  // taken in whichever direction is non-negative.
  always_comb begin
    err = s2_exact - s2_c;
    if (s2_c > s2_exact) begin
      err = s2_c - s2_exact;
    end
  end

  always_comb begin
    acc_sum  = SW'(err_acc) + SW'(err);
    acc_next = acc_sum[ACC_W-1:0];
    if (acc_sum > SW'({ACC_W{1'b1}})) begin
      acc_next = '1;
    end
  end

  // Error monitor, updated on each output handshake. A clear in the same
  // cycle wins and the sample is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc    <= '0;
      err_max    <= '0;
      sample_cnt <= '0;
    end else if (clr_stats) begin
      err_acc    <= '0;
      err_max    <= '0;
      sample_cnt <= '0;
    end else if (out_hs) begin
      err_acc <= acc_next;
      if (err > err_max) begin
        err_max <= err;
      end
      if (sample_cnt != '1) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_apx_add_pipe.sv
// tb_apx_add_pipe
//   Scoreboard bench for apx_add_pipe. Expected sums are queued when a beat is
//   accepted and compared while the result is presented. A second instance
//   with a 10-bit accumulator shares the same stream to exercise saturation.
module tb_apx_add_pipe;

  typedef struct {
    logic [16:0] c;
    logic [16:0] exact;
  } sb_t;

  logic clk;
  logic rst_n;
  logic clr_stats;
  logic rand_bp;

  logic [31:0] err_acc;
  logic [16:0] err_max;
  logic [15:0] sample_cnt;
  logic [9:0]  err_acc10;
  logic [16:0] err_max10;
  logic [15:0] sample_cnt10;

  int vectors;
  int miscompares;
  int last_wait;

  sb_t sb[$];

  logic [31:0] m_acc;
  logic [16:0] m_max;
  logic [15:0] m_cnt;

  apx_add_pipe_if #(.DWA(16), .DWB(16), .DW_AC_MAX(8)) io();
  apx_add_pipe_if #(.DWA(16), .DWB(16), .DW_AC_MAX(8)) io10();

  apx_add_pipe #(.DWA(16), .DWB(16), .DW_AC_MAX(8), .ACC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .io(io), .clr_stats(clr_stats),
    .err_acc(err_acc), .err_max(err_max), .sample_cnt(sample_cnt)
  );

  apx_add_pipe #(.DWA(16), .DWB(16), .DW_AC_MAX(8), .ACC_W(10), .CNT_W(16)) dut10 (
    .clk(clk), .rst_n(rst_n), .io(io10), .clr_stats(clr_stats),
    .err_acc(err_acc10), .err_max(err_max10), .sample_cnt(sample_cnt10)
  );

  assign io10.in_valid  = io.in_valid;
  assign io10.a         = io.a;
  assign io10.b         = io.b;
  assign io10.mode      = io.mode;
  assign io10.k         = io.k;
  assign io10.out_ready = io.out_ready;

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference approximate sum built from shifted operands rather than masks
  function automatic logic [16:0] model_c(input logic [15:0] av, input logic [15:0] bv,
                                          input logic [1:0] m, input logic [3:0] kv);
    int kc;
    logic [16:0] hi;
    logic [15:0] low_ones;
    kc = (kv > 4'd8) ? 8 : int'(kv);
    if (m == 2'd0 || kc == 0) return {1'b0, av} + {1'b0, bv};
    hi = (17'(av >> kc) + 17'(bv >> kc)) << kc;
    low_ones = (16'd1 << kc) - 16'd1;
    case (m)
      2'd1:    return hi;
      2'd2:    return hi | 17'((av | bv) & low_ones);
      default: return hi | (17'd1 << (kc - 1));
    endcase
  endfunction

  // Single comparison point; counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Present one beat and hold it until accepted; the expected result is
  // queued at the acceptance edge. Called just after a rising edge.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                               input logic [1:0] m, input logic [3:0] kv, input logic [16:0] exp_c);
    logic took;
    sb_t e;
    int n;
    n = 0;
    took = 1'b0;
    io.in_valid = 1'b1;
    io.a = av;
    io.b = bv;
    io.mode = m;
    io.k = kv;
    while (!took && n < 64) begin
      @(negedge clk);
      took = io.in_ready;
      if (took) begin
        e.c = exp_c;
        e.exact = {1'b0, av} + {1'b0, bv};
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end
    last_wait = n;
    if (!took) checkOutput("in_accept_timeout", 64'd0, 64'd1);
    io.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((sb.size() != 0 || io.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic pulseClear();
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
  endtask

  // Output side of the scoreboard plus an independent model of the monitor
  always @(negedge clk) begin
    sb_t e;
    logic [16:0] d;
    logic [32:0] s;
    if (!rst_n) begin
      m_acc = '0;
      m_max = '0;
      m_cnt = '0;
    end else begin
      if (io.out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 64'(io.c), 64'h1_DEAD);
        end else begin
          checkOutput("c", 64'(io.c), 64'(sb[0].c));
          if (io.out_ready) begin
            e = sb.pop_front();
            d = (e.c > e.exact) ? e.c - e.exact : e.exact - e.c;
            if (!clr_stats) begin
              s = {1'b0, m_acc} + 33'(d);
              m_acc = s[32] ? 32'hFFFF_FFFF : s[31:0];
              if (d > m_max) m_max = d;
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
          end
        end
      end
      if (clr_stats) begin
        m_acc = '0;
        m_max = '0;
        m_cnt = '0;
      end
    end
  end

  // Random back-pressure, enabled only during the random phase
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      io.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  rm;
    logic [3:0]  rk;
    vectors = 0;
    miscompares = 0;
    rand_bp = 1'b0;
    rst_n = 1'b0;
    clr_stats = 1'b0;
    io.in_valid = 1'b0;
    io.a = '0;
    io.b = '0;
    io.mode = '0;
    io.k = '0;
    io.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(io.out_valid), 64'd0);
    checkOutput("rst_c", 64'(io.c), 64'd0);
    checkOutput("rst_err_acc", 64'(err_acc), 64'd0);
    checkOutput("rst_err_max", 64'(err_max), 64'd0);
    checkOutput("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(io.in_ready), 64'd1);
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;

    // One beat per mode, k = 8
    applyStimulus(16'h00FF, 16'h0001, 2'd0, 4'd8, 17'h00100);
    applyStimulus(16'h00FF, 16'h0001, 2'd1, 4'd8, 17'h00000);
    applyStimulus(16'h00FF, 16'h0001, 2'd2, 4'd8, 17'h000FF);
    applyStimulus(16'h00FF, 16'h0001, 2'd3, 4'd8, 17'h00080);
    waitDrain();
    @(negedge clk);
    checkOutput("modes_err_acc", 64'(err_acc), 64'd385);
    checkOutput("modes_err_max", 64'(err_max), 64'd256);
    checkOutput("modes_sample_cnt", 64'(sample_cnt), 64'd4);

    // Carry-out and k clamp
    @(posedge clk);
    #1;
    applyStimulus(16'hFFFF, 16'h0001, 2'd0, 4'd0, 17'h10000);
    applyStimulus(16'h0F0F, 16'h0F0F, 2'd1, 4'd15, 17'h01E00);
    waitDrain();

    // Clear coinciding with an output handshake
    @(posedge clk);
    #1;
    applyStimulus(16'h00FF, 16'h0001, 2'd1, 4'd8, 17'h00000);
    @(posedge clk);
    #1;
    clr_stats = 1'b1;
    @(negedge clk);
    checkOutput("clr_hs_out_valid", 64'(io.out_valid), 64'd1);
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    @(negedge clk);
    checkOutput("clr_err_acc", 64'(err_acc), 64'd0);
    checkOutput("clr_err_max", 64'(err_max), 64'd0);
    checkOutput("clr_sample_cnt", 64'(sample_cnt), 64'd0);

    // Back-pressure: two beats fit, the third is refused
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    applyStimulus(16'h1111, 16'h2222, 2'd0, 4'd0, 17'h03333);
    checkOutput("bp_beat1_wait", 64'(last_wait), 64'd1);
    applyStimulus(16'h0123, 16'h0456, 2'd2, 4'd4, model_c(16'h0123, 16'h0456, 2'd2, 4'd4));
    checkOutput("bp_beat2_wait", 64'(last_wait), 64'd1);
    io.in_valid = 1'b1;
    io.a = 16'hABCD;
    io.b = 16'h1357;
    io.mode = 2'd3;
    io.k = 4'd6;
    @(negedge clk);
    checkOutput("bp_in_ready_low", 64'(io.in_ready), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("bp_stall_in_ready", 64'(io.in_ready), 64'd0);
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_stream_valid", 64'(io.out_valid), 64'd1);
      if (i == 0) begin
        checkOutput("bp_release_in_ready", 64'(io.in_ready), 64'd1);
        sb.push_back('{c: model_c(16'hABCD, 16'h1357, 2'd3, 4'd6),
                       exact: 17'h0ABCD + 17'h01357});
      end
      @(posedge clk);
      #1;
      if (i == 0) io.in_valid = 1'b0;
    end
    waitDrain();

    // Accumulator saturation on the 10-bit instance
    @(posedge clk);
    #1;
    pulseClear();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(16'h00FF, 16'h0001, 2'd1, 4'd8, 17'h00000);
    end
    waitDrain();
    @(negedge clk);
    checkOutput("sat_err_acc10", 64'(err_acc10), 64'h3FF);
    checkOutput("sat_sample_cnt10", 64'(sample_cnt10), 64'd5);
    checkOutput("sat_err_acc32", 64'(err_acc), 64'd1280);

    // Random traffic with random back-pressure
    @(posedge clk);
    #1;
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 2'($urandom_range(0, 3));
      rk = 4'($urandom_range(0, 15));
      applyStimulus(ra, rb, rm, rk, model_c(ra, rb, rm, rk));
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    io.out_ready = 1'b1;
    waitDrain();
    @(negedge clk);
    checkOutput("rand_err_acc", 64'(err_acc), 64'(m_acc));
    checkOutput("rand_err_max", 64'(err_max), 64'(m_max));
    checkOutput("rand_sample_cnt", 64'(sample_cnt), 64'(m_cnt));

    // Asynchronous reset with two beats in flight
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    applyStimulus(16'h4444, 16'h1111, 2'd0, 4'd0, 17'h05555);
    applyStimulus(16'h7777, 16'h1111, 2'd1, 4'd3, model_c(16'h7777, 16'h1111, 2'd1, 4'd3));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(io.out_valid), 64'd0);
    checkOutput("arst_err_acc", 64'(err_acc), 64'd0);
    checkOutput("arst_err_max", 64'(err_max), 64'd0);
    checkOutput("arst_sample_cnt", 64'(sample_cnt), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("arst_in_ready", 64'(io.in_ready), 64'd1);
    checkOutput("arst_discard", 64'(io.out_valid), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(16'h1234, 16'h4321, 2'd3, 4'd5, model_c(16'h1234, 16'h4321, 2'd3, 4'd5));
    @(negedge clk);
    checkOutput("lat_cycle1_valid", 64'(io.out_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_cycle2_valid", 64'(io.out_valid), 64'd1);
    waitDrain();
    @(negedge clk);
    checkOutput("arst_fresh_cnt", 64'(sample_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
